dest_pipe: RTL and testbench

Destination-tracking pipeline for the Beta core: it carries each instruction's destination register, result value and return PC from the RF stage through EX, MEM and WB. It is the producer side of operand bypassing. It drives the per-stage Rc, Y and PC bypass values and branch/jump flags that the operand muxes consume, the final write-back value, and the register-file write port. It also detects load-use hazards and issues the stall/bubble.

---
 rtl/dest_pipe_if.sv | 52 +++++
 rtl/dest_pipe.sv | 129 ++++++++++++
 tb/tb_dest_pipe.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dest_pipe_if.sv
// dest_pipe_if: RF-side inputs and bypass/write-back outputs of the Beta
// destination-tracking pipeline, bundled for a single port connection.
//   master : the core side (decode, ALU, data memory), drives the RF-stage
//            instruction fields and consumes stall, bypass values and the
//            register-file write port.
//   slave  : dest_pipe itself.
interface dest_pipe_if;
  logic        hold;
  logic [4:0]  rc_rf;
  logic        wr_rf;
  logic        op_ld_rf;
  logic        op_br_or_jmp_rf;
  logic [31:0] pc_rf;
  logic        annul_ex;
  logic [4:0]  ra_rf;
  logic [4:0]  rb_rf;
  logic        ra_used;
  logic        rb_used;
  logic [31:0] alu_y;
  logic [31:0] mem_rdata;

  logic        stall;
  logic [4:0]  rc_ex;
  logic [4:0]  rc_mem;
  logic [4:0]  rc_wb;
  logic [31:0] ex_y_bypass;
  logic [31:0] ex_pc_bypass;
  logic [31:0] mem_pc_bypass;
  logic [31:0] mem_y_bypass;
  logic [31:0] wb_bypass;
  logic        op_br_or_jmp_ex;
  logic        op_br_or_jmp_mem;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  modport master (
    output hold, rc_rf, wr_rf, op_ld_rf, op_br_or_jmp_rf, pc_rf, annul_ex,
           ra_rf, rb_rf, ra_used, rb_used, alu_y, mem_rdata,
    input  stall, rc_ex, rc_mem, rc_wb, ex_y_bypass, ex_pc_bypass,
           mem_pc_bypass, mem_y_bypass, wb_bypass, op_br_or_jmp_ex,
           op_br_or_jmp_mem, rf_we, rf_wa, rf_wd
  );

  modport slave (
    input  hold, rc_rf, wr_rf, op_ld_rf, op_br_or_jmp_rf, pc_rf, annul_ex,
           ra_rf, rb_rf, ra_used, rb_used, alu_y, mem_rdata,
    output stall, rc_ex, rc_mem, rc_wb, ex_y_bypass, ex_pc_bypass,
           mem_pc_bypass, mem_y_bypass, wb_bypass, op_br_or_jmp_ex,
           op_br_or_jmp_mem, rf_we, rf_wa, rf_wd
  );
endinterface

// File: rtl/dest_pipe.sv
// dest_pipe: carries destination register, return PC and result of each Beta
// instruction from RF through EX (_p0), MEM (_p1) and WB (_p2). Produces the
// per-stage bypass values, the register-file write port and the load-use
// stall.
// Ports:
//   clk  : core clock, rising edge
//   rst  : synchronous active-high reset (all stages become bubbles)
//   dp   : dest_pipe_if.slave, RF-stage instruction fields, alu_y, mem_rdata,
//          hold/annul_ex in; stall, rc_ex/mem/wb, bypass values, rf_we/wa/wd out
module dest_pipe (
  input  logic        clk,
  input  logic        rst,
  dest_pipe_if.slave  dp
);

  localparam logic [4:0] R31 = 5'd31;

  // EX stage
  logic [4:0]  rc_p0;
  logic [31:0] pc_p0;
  logic        ld_p0;
  logic        bj_p0;
  // MEM stage
  logic [4:0]  rc_p1;
  logic [31:0] pc_p1;
  logic [31:0] y_p1;
  logic        ld_p1;
  logic        bj_p1;
  // WB stage
  logic [4:0]  rc_p2;
  logic [31:0] pc_p2;
  logic [31:0] y_p2;
  logic        ld_p2;
  logic        bj_p2;

  logic haz_a;
  logic haz_b;
  logic bubble_ex;

  function automatic logic src_hazard(
    input logic       used,
    input logic [4:0] src,
    input logic [4:0] rc_ex_s,
    input logic       ld_ex_s,
    input logic [4:0] rc_mem_s,
    input logic       ld_mem_s
  );
    // Load data only appears in WB, so a load still in EX or MEM blocks readers.
    return used && (src != R31) &&
           (((src == rc_ex_s) && ld_ex_s) || ((src == rc_mem_s) && ld_mem_s));
  endfunction

  function automatic logic [31:0] wb_select(
    input logic        ld,
    input logic        bj,
    input logic [31:0] rdata,
    input logic [31:0] pc,
    input logic [31:0] y
  );
    return ld ? rdata : (bj ? pc : y);
  endfunction

  always_comb begin
    haz_a     = src_hazard(dp.ra_used, dp.ra_rf, rc_p0, ld_p0, rc_p1, ld_p1);
    haz_b     = src_hazard(dp.rb_used, dp.rb_rf, rc_p0, ld_p0, rc_p1, ld_p1);
    bubble_ex = haz_a || haz_b || dp.annul_ex;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rc_p0 <= R31;
      pc_p0 <= '0;
      ld_p0 <= 1'b0;
      bj_p0 <= 1'b0;
      rc_p1 <= R31;
      pc_p1 <= '0;
      y_p1  <= '0;
      ld_p1 <= 1'b0;
      bj_p1 <= 1'b0;
      rc_p2 <= R31;
      pc_p2 <= '0;
      y_p2  <= '0;
      ld_p2 <= 1'b0;
      bj_p2 <= 1'b0;
    end else if (!dp.hold) begin
      // RF -> EX
      if (bubble_ex) begin
        rc_p0 <= R31;
        pc_p0 <= '0;
        ld_p0 <= 1'b0;
        bj_p0 <= 1'b0;
      end else begin
        rc_p0 <= dp.wr_rf ? dp.rc_rf : R31;
        pc_p0 <= dp.pc_rf;
        ld_p0 <= dp.op_ld_rf;
        bj_p0 <= dp.op_br_or_jmp_rf;
      end
      // EX -> MEM
      rc_p1 <= rc_p0;
      pc_p1 <= pc_p0;
      y_p1  <= dp.alu_y;
      ld_p1 <= ld_p0;
      bj_p1 <= bj_p0;
      // MEM -> WB
      rc_p2 <= rc_p1;
      pc_p2 <= pc_p1;
      y_p2  <= y_p1;
      ld_p2 <= ld_p1;
      bj_p2 <= bj_p1;
    end
  end

  assign dp.stall            = haz_a || haz_b;
  assign dp.rc_ex            = rc_p0;
  assign dp.rc_mem           = rc_p1;
  assign dp.rc_wb            = rc_p2;
  assign dp.ex_y_bypass      = dp.alu_y;
  assign dp.ex_pc_bypass     = pc_p0;
  assign dp.mem_pc_bypass    = pc_p1;
  assign dp.mem_y_bypass     = y_p1;
  assign dp.wb_bypass        = wb_select(ld_p2, bj_p2, dp.mem_rdata, pc_p2, y_p2);
  assign dp.op_br_or_jmp_ex  = bj_p0;
  assign dp.op_br_or_jmp_mem = bj_p1;
  // A frozen WB stage must not write; it commits once hold releases.
  assign dp.rf_we            = (rc_p2 != R31) && !dp.hold;
  assign dp.rf_wa            = rc_p2;
  assign dp.rf_wd            = dp.wb_bypass;

endmodule

// File: tb/tb_dest_pipe.sv
module tb_dest_pipe;

  logic clk;
  logic rst;
  dest_pipe_if dp ();

  dest_pipe dut (
    .clk (clk),
    .rst (rst),
    .dp  (dp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: in-flight instruction records, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct packed {
    logic [4:0]  rc;
    logic [31:0] pc;
    logic [31:0] y;
    logic        ld;
    logic        bj;
  } ins_t;

  localparam ins_t BUB = '{rc: 5'd31, pc: 32'd0, y: 32'd0, ld: 1'b0, bj: 1'b0};

  ins_t pipe[$];
  bit   model_ok = 0;
  bit   last_stall = 0;

  function automatic bit reads_pending_load(input logic used, input logic [4:0] src);
    if (!used || src == 5'd31) return 0;
    for (int i = 0; i < 2; i++)
      if (pipe[i].ld && pipe[i].rc == src) return 1;
    return 0;
  endfunction

  function automatic bit model_stall();
    return reads_pending_load(dp.ra_used, dp.ra_rf) || reads_pending_load(dp.rb_used, dp.rb_rf);
  endfunction

  function automatic logic [31:0] model_wb();
    if (pipe[2].ld) return dp.mem_rdata;
    if (pipe[2].bj) return pipe[2].pc;
    return pipe[2].y;
  endfunction

  task automatic compare_model();
    logic [31:0] wbv;
    wbv = model_wb();
    check_eq("stall",     {31'd0, dp.stall},            {31'd0, model_stall()});
    check_eq("rc_ex",     {27'd0, dp.rc_ex},            {27'd0, pipe[0].rc});
    check_eq("rc_mem",    {27'd0, dp.rc_mem},           {27'd0, pipe[1].rc});
    check_eq("rc_wb",     {27'd0, dp.rc_wb},            {27'd0, pipe[2].rc});
    check_eq("ex_y",      dp.ex_y_bypass,               dp.alu_y);
    check_eq("ex_pc",     dp.ex_pc_bypass,              pipe[0].pc);
    check_eq("mem_pc",    dp.mem_pc_bypass,             pipe[1].pc);
    check_eq("mem_y",     dp.mem_y_bypass,              pipe[1].y);
    check_eq("wb_bypass", dp.wb_bypass,                 wbv);
    check_eq("bj_ex",     {31'd0, dp.op_br_or_jmp_ex},  {31'd0, pipe[0].bj});
    check_eq("bj_mem",    {31'd0, dp.op_br_or_jmp_mem}, {31'd0, pipe[1].bj});
    check_eq("rf_we",     {31'd0, dp.rf_we},            {31'd0, (pipe[2].rc != 5'd31) && !dp.hold});
    check_eq("rf_wa",     {27'd0, dp.rf_wa},            {27'd0, pipe[2].rc});
    check_eq("rf_wd",     dp.rf_wd,                     wbv);
  endtask

  task automatic model_edge();
    ins_t n;
    bit   st;
    st = model_stall();
    if (rst) begin
      pipe = '{BUB, BUB, BUB};
      model_ok = 1;
      last_stall = 0;
    end else if (!dp.hold) begin
      if (st || dp.annul_ex) n = BUB;
      else n = '{rc: dp.wr_rf ? dp.rc_rf : 5'd31, pc: dp.pc_rf, y: 32'd0,
                 ld: dp.op_ld_rf, bj: dp.op_br_or_jmp_rf};
      pipe[0].y = dp.alu_y;
      pipe.push_front(n);
      void'(pipe.pop_back());
      last_stall = st;
    end else begin
      last_stall = st;
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clk);
    if (model_ok) compare_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [4:0] rc, input logic wr, input logic ld, input logic bj,
                       input logic [31:0] pc, input logic [4:0] ra, input logic ra_u,
                       input logic [4:0] rb, input logic rb_u);
    dp.rc_rf = rc;  dp.wr_rf = wr;  dp.op_ld_rf = ld;  dp.op_br_or_jmp_rf = bj;
    dp.pc_rf = pc;  dp.ra_rf = ra;  dp.ra_used = ra_u; dp.rb_rf = rb; dp.rb_used = rb_u;
  endtask

  task automatic drive_bubble();
    drive(5'd31, 1'b0, 1'b0, 1'b0, 32'd0, 5'd31, 1'b0, 5'd31, 1'b0);
  endtask

  initial begin
    pipe = '{BUB, BUB, BUB};
    rst = 1'b1;
    dp.hold = 1'b0; dp.annul_ex = 1'b0; dp.alu_y = 32'd0; dp.mem_rdata = 32'd0;
    drive_bubble();

    // Reset
    tick(); tick();
    rst = 1'b0;
    #1;
    check_eq("rst_rc_ex",  {27'd0, dp.rc_ex},  32'd31);
    check_eq("rst_rc_mem", {27'd0, dp.rc_mem}, 32'd31);
    check_eq("rst_rc_wb",  {27'd0, dp.rc_wb},  32'd31);
    check_eq("rst_rf_we",  {31'd0, dp.rf_we},  32'd0);
    check_eq("rst_stall",  {31'd0, dp.stall},  32'd0);
    check_eq("rst_wb",     dp.wb_bypass,       32'd0);
    tick();

    // ALU chain: ADDC r1, then a reader of r1
    drive(5'd1, 1'b1, 1'b0, 1'b0, 32'h40, 5'd31, 1'b0, 5'd31, 1'b0);
    tick();
    drive(5'd4, 1'b0, 1'b0, 1'b0, 32'h44, 5'd1, 1'b1, 5'd31, 1'b0);
    dp.alu_y = 32'h5;
    #1;
    check_eq("alu_rc_ex", {27'd0, dp.rc_ex}, 32'd1);
    check_eq("alu_ex_y",  dp.ex_y_bypass,    32'h5);
    check_eq("alu_stall", {31'd0, dp.stall}, 32'd0);
    tick();
    drive_bubble();
    dp.alu_y = 32'h77;
    #1;
    check_eq("alu_mem_y", dp.mem_y_bypass, 32'h5);
    tick();
    check_eq("alu_we", {31'd0, dp.rf_we}, 32'd1);
    check_eq("alu_wa", {27'd0, dp.rf_wa}, 32'd1);
    check_eq("alu_wd", dp.rf_wd,          32'h5);
    tick();

    // Load-use: LD r2, then an immediate reader of r2
    drive(5'd2, 1'b1, 1'b1, 1'b0, 32'h80, 5'd31, 1'b0, 5'd31, 1'b0);
    tick();
    drive(5'd5, 1'b1, 1'b0, 1'b0, 32'h84, 5'd2, 1'b1, 5'd31, 1'b0);
    #1;
    check_eq("ld_stall1", {31'd0, dp.stall}, 32'd1);
    tick();
    check_eq("ld_stall2", {31'd0, dp.stall}, 32'd1);
    check_eq("ld_bub1",   {27'd0, dp.rc_ex}, 32'd31);
    tick();
    dp.mem_rdata = 32'hDEAD;
    #1;
    check_eq("ld_stall3", {31'd0, dp.stall}, 32'd0);
    check_eq("ld_bub2",   {27'd0, dp.rc_ex}, 32'd31);
    check_eq("ld_wb",     dp.wb_bypass,      32'hDEAD);
    check_eq("ld_wa",     {27'd0, dp.rf_wa}, 32'd2);
    tick();
    check_eq("ld_use_ex", {27'd0, dp.rc_ex}, 32'd5);
    drive_bubble();
    tick();

    // Jump and link into r28
    drive(5'd28, 1'b1, 1'b0, 1'b1, 32'h104, 5'd31, 1'b0, 5'd31, 1'b0);
    tick();
    drive_bubble();
    dp.alu_y = 32'h999;
    #1;
    check_eq("jmp_bj_ex", {31'd0, dp.op_br_or_jmp_ex}, 32'd1);
    check_eq("jmp_pc_ex", dp.ex_pc_bypass,             32'h104);
    tick(); tick();
    check_eq("jmp_wa", {27'd0, dp.rf_wa}, 32'd28);
    check_eq("jmp_wd", dp.rf_wd,          32'h104);
    check_eq("jmp_we", {31'd0, dp.rf_we}, 32'd1);

    // Annul after a BEQ, then ST
    drive(5'd31, 1'b0, 1'b0, 1'b1, 32'h200, 5'd31, 1'b0, 5'd31, 1'b0);
    tick();
    drive(5'd7, 1'b1, 1'b0, 1'b0, 32'h204, 5'd31, 1'b0, 5'd31, 1'b0);
    dp.annul_ex = 1'b1;
    tick();
    dp.annul_ex = 1'b0;
    check_eq("annul_rc_ex", {27'd0, dp.rc_ex}, 32'd31);
    drive(5'd3, 1'b0, 1'b0, 1'b0, 32'h300, 5'd31, 1'b0, 5'd31, 1'b0);
    tick();
    drive_bubble();
    tick(); tick();
    check_eq("st_no_we", {31'd0, dp.rf_we}, 32'd0);

    // Hold mid-stream
    drive(5'd9, 1'b1, 1'b0, 1'b0, 32'h400, 5'd31, 1'b0, 5'd31, 1'b0);
    tick();
    drive(5'd10, 1'b1, 1'b0, 1'b0, 32'h404, 5'd31, 1'b0, 5'd31, 1'b0);
    tick();
    drive(5'd11, 1'b1, 1'b0, 1'b0, 32'h408, 5'd31, 1'b0, 5'd31, 1'b0);
    tick();
    dp.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_rc_ex",  {27'd0, dp.rc_ex},    32'd11);
      check_eq("hold_rc_wb",  {27'd0, dp.rc_wb},    32'd9);
      check_eq("hold_pc_mem", dp.mem_pc_bypass,     32'h404);
      check_eq("hold_we",     {31'd0, dp.rf_we},    32'd0);
    end
    dp.hold = 1'b0;
    drive_bubble();
    #1;
    check_eq("rel_we", {31'd0, dp.rf_we}, 32'd1);
    check_eq("rel_wa", {27'd0, dp.rf_wa}, 32'd9);
    tick();
    check_eq("rel_wa2", {27'd0, dp.rf_wa}, 32'd10);
    tick();
    check_eq("rel_wa3", {27'd0, dp.rf_wa}, 32'd11);
    tick();

    // Mid-stream reset discards in-flight writes
    drive(5'd12, 1'b1, 1'b0, 1'b0, 32'h500, 5'd31, 1'b0, 5'd31, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_bubble();
    #1;
    check_eq("mrst_we", {31'd0, dp.rf_we}, 32'd0);
    check_eq("mrst_rc", {27'd0, dp.rc_mem}, 32'd31);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      dp.alu_y     = $urandom;
      dp.mem_rdata = $urandom;
      dp.hold      = ($urandom_range(0, 9) == 0);
      dp.annul_ex  = ($urandom_range(0, 7) == 0);
      rst          = ($urandom_range(0, 149) == 0);
      if (!last_stall) begin
        drive(($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 5)),
              1'($urandom_range(0, 4) != 0),
              1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 5) == 0),
              $urandom,
              ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5)),
              1'($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5)),
              1'($urandom_range(0, 1)));
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
